turbo_itl_ctrl: RTL

//  Sequencer for the turbo interleaver memory: ROM of permutation addresses plus dual-port symbol RAM.
//  Per block it loads blk_len input symbols into the RAM, then streams them out in permuted order.

---
 rtl/turbo_itl_ctrl_if.sv | 41 ++++
 rtl/turbo_itl_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/turbo_itl_ctrl_if.sv
// turbo_itl_ctrl_if: block control, symbol streams and ROM/RAM ports of the turbo interleaver sequencer.
// master = sequencer side, slave = surrounding datapath / memories.
interface turbo_itl_ctrl_if #(
    parameter int unsigned D_WIDTH = 13,
    parameter int unsigned A_WIDTH = 16,
    parameter int unsigned S_WIDTH = 13
);
    logic               start;
    logic [A_WIDTH-1:0] blk_len;
    logic               mode;
    logic               in_valid;
    logic               in_ready;
    logic [S_WIDTH-1:0] in_data;
    logic [A_WIDTH-1:0] rom_addr;
    logic [D_WIDTH-1:0] rom_data;
    logic               ram_wen;
    logic [A_WIDTH-1:0] ram_waddr;
    logic [S_WIDTH-1:0] ram_wdata;
    logic [A_WIDTH-1:0] ram_raddr;
    logic [S_WIDTH-1:0] ram_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [S_WIDTH-1:0] out_data;
    logic               out_last;
    logic               busy;
    logic               done;
    logic               err;
    logic               err_range;

    modport master (
        input  start, blk_len, mode, in_valid, in_data, rom_data, ram_rdata, out_ready,
        output in_ready, rom_addr, ram_wen, ram_waddr, ram_wdata, ram_raddr,
               out_valid, out_data, out_last, busy, done, err, err_range
    );

    modport slave (
        output start, blk_len, mode, in_valid, in_data, rom_data, ram_rdata, out_ready,
        input  in_ready, rom_addr, ram_wen, ram_waddr, ram_wdata, ram_raddr,
               out_valid, out_data, out_last, busy, done, err, err_range
    );
endinterface

// File: rtl/turbo_itl_ctrl.sv
// turbo_itl_ctrl: loads a block into the symbol RAM, then streams it out in ROM-permuted order.
// Define TURBO_ITL_RANGE_CHK_EN to check ROM indices against the block length (err_range).
module turbo_itl_ctrl #(
    parameter int unsigned D_WIDTH = 13,
    parameter int unsigned A_WIDTH = 16,
    parameter int unsigned S_WIDTH = 13
) (
    input logic              clk,
    input logic              n_rst,
    turbo_itl_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FIN} state_t;

    localparam logic [A_WIDTH:0] MAX_LEN = (A_WIDTH+1)'(1) << D_WIDTH;

    state_t             state, state_n;
    logic [A_WIDTH-1:0] len_q, wr_cnt, rd_cnt, last_idx;
    logic               mode_q, first;
    logic               v1, last1, v2, last2, zero2;
    logic [S_WIDTH-1:0] fifo_data [4];
    logic               fifo_last [4];
    logic [1:0]         wr_ptr, rd_ptr;
    logic [2:0]         occ;
    logic               err_q;
    logic               start_ok, start_acc, accept, issue, push, pop, rom_bad, range_hit;

    assign last_idx  = len_q - A_WIDTH'(1);
    assign start_ok  = (bus.blk_len != '0) && ({1'b0, bus.blk_len} <= MAX_LEN);
    assign start_acc = (state == IDLE) && bus.start && start_ok;
    assign push      = v2;
    assign bus.out_valid = (occ != 3'd0);
    assign pop       = bus.out_valid && bus.out_ready;
    assign bus.out_data  = bus.out_valid ? fifo_data[rd_ptr] : '0;
    assign bus.out_last  = bus.out_valid && fifo_last[rd_ptr];
    assign bus.busy  = (state != IDLE);
    assign bus.done  = (state == FIN);
    assign bus.err   = err_q;

    always_comb begin
        state_n       = state;
        bus.in_ready  = 1'b0;
        bus.ram_wen   = 1'b0;
        bus.ram_waddr = '0;
        bus.ram_wdata = '0;
        bus.rom_addr  = '0;
        bus.ram_raddr = '0;
        accept        = 1'b0;
        issue         = 1'b0;
        range_hit     = 1'b0;
        case (state)
            IDLE: if (start_acc) state_n = LOAD;
            LOAD: begin
                // mode1 spends the first cycle fetching the ROM entry for index 0
                bus.in_ready = mode_q ? !first : 1'b1;
                accept       = bus.in_valid && bus.in_ready;
                if (mode_q) begin
                    bus.rom_addr  = accept ? wr_cnt + A_WIDTH'(1) : wr_cnt;
                    bus.ram_waddr = A_WIDTH'(bus.rom_data);
                    range_hit     = accept && rom_bad;
                end else begin
                    bus.ram_waddr = wr_cnt;
                end
                bus.ram_wen   = accept && !range_hit;
                bus.ram_wdata = bus.in_data;
                if (accept && wr_cnt == last_idx) state_n = DRAIN;
            end
            DRAIN: begin
                // credit check: buffered entries plus reads still in the pipe never exceed 4
                issue = (rd_cnt != len_q) &&
                        ((occ + {2'b0, v1} + {2'b0, v2}) < 3'd4);
                if (mode_q) begin
                    bus.ram_raddr = rd_cnt;
                end else begin
                    bus.rom_addr  = rd_cnt;
                    bus.ram_raddr = A_WIDTH'(bus.rom_data);
                    range_hit     = v1 && rom_bad;
                end
                if (pop && fifo_last[rd_ptr]) state_n = FIN;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state  <= IDLE;
            len_q  <= '0;
            mode_q <= 1'b0;
            wr_cnt <= '0;
            rd_cnt <= '0;
            first  <= 1'b0;
            v1     <= 1'b0;
            last1  <= 1'b0;
            v2     <= 1'b0;
            last2  <= 1'b0;
            zero2  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_n;
            err_q <= (state == IDLE) && bus.start && !start_ok;
            first <= start_acc;
            if (start_acc) begin
                len_q  <= bus.blk_len;
                mode_q <= bus.mode;
                wr_cnt <= '0;
                rd_cnt <= '0;
            end else begin
                if (accept) wr_cnt <= wr_cnt + A_WIDTH'(1);
                if (issue)  rd_cnt <= rd_cnt + A_WIDTH'(1);
            end
            v1    <= issue && !mode_q;
            last1 <= (rd_cnt == last_idx);
            v2    <= mode_q ? issue : v1;
            last2 <= mode_q ? (rd_cnt == last_idx) : last1;
            zero2 <= mode_q ? 1'b0 : range_hit;
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr] <= zero2 ? '0 : bus.ram_rdata;
            fifo_last[wr_ptr] <= last2;
        end
    end

`ifdef TURBO_ITL_RANGE_CHK_EN
    logic err_range_q;
    assign rom_bad       = A_WIDTH'(bus.rom_data) >= len_q;
    assign bus.err_range = err_range_q;
    always_ff @(posedge clk) begin
        if (!n_rst)         err_range_q <= 1'b0;
        else if (start_acc) err_range_q <= 1'b0;
        else if (range_hit) err_range_q <= 1'b1;
    end
`else
    assign rom_bad       = 1'b0;
    assign bus.err_range = 1'b0;
`endif
endmodule
